alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : RV integer ALU with valid/ready handshake. Optional iterative
//            M-extension unit compiled in with macro ALU_SEQ_MULDIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [6:0]      opcode_in,
    input  logic [2:0]      funct3_in,
    input  logic [6:0]      funct7_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    input  logic [XLEN-1:0] imm_value_in,
    output logic            valid_out,
    output logic [XLEN-1:0] result_out,
    output logic            illegal_out
);

    localparam int         SHW        = $clog2(XLEN);
    localparam logic [6:0] C_OP_REG   = 7'h33;
    localparam logic [6:0] C_OP_IMM   = 7'h13;
    localparam logic [6:0] C_OP_LOAD  = 7'h03;
    localparam logic [6:0] C_OP_STORE = 7'h23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic            valid_q;
    logic            illegal_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] w_src2;
    logic [XLEN-1:0] w_alu;
    logic [SHW-1:0]  w_shamt;
    logic            w_legal;
    logic            w_sub;
    logic            w_sra;

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [SHW-1:0]    cnt_q;
    logic [2:0]        mdop_q;
    logic              negq_q;
    logic              negr_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   hi_d;
    logic [XLEN-1:0]   lo_d;
    logic              w_is_md;
    logic              w_s1;
    logic              w_s2;
    logic              w_n1;
    logic              w_n2;
    logic              w_fast;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN-1:0]   w_md_res;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_prod;

    // Iteration runs on magnitudes; signs are reapplied when the result is taken.
    always_comb begin
        w_s1       = funct3_in[2] ? ~funct3_in[0]
                                  : (funct3_in[1:0] == 2'b01 || funct3_in[1:0] == 2'b10);
        w_s2       = funct3_in[2] ? ~funct3_in[0] : (funct3_in[1:0] == 2'b01);
        w_n1       = w_s1 & rs1_value_in[XLEN-1];
        w_n2       = w_s2 & rs2_value_in[XLEN-1];
        w_abs1     = w_n1 ? -rs1_value_in : rs1_value_in;
        w_abs2     = w_n2 ? -rs2_value_in : rs2_value_in;
        w_fast     = 1'b0;
        w_fast_res = '0;
        if (funct3_in[2]) begin
            if (rs2_value_in == '0) begin
                w_fast     = 1'b1;
                w_fast_res = funct3_in[1] ? rs1_value_in : '1;
            end else if (!funct3_in[0] && rs1_value_in == C_MIN && rs2_value_in == '1) begin
                w_fast     = 1'b1;
                w_fast_res = funct3_in[1] ? '0 : rs1_value_in;
            end
        end
    end

    always_comb begin
        w_msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        w_rsh  = {hi_q, lo_q[XLEN-1]};
        w_diff = w_rsh - {1'b0, a_q};
        if (mdop_q[2]) begin
            hi_d = w_diff[XLEN] ? w_rsh[XLEN-1:0] : w_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
            hi_d = w_msum[XLEN:1];
            lo_d = {w_msum[0], lo_q[XLEN-1:1]};
        end
        w_prod = negq_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        if (!mdop_q[2]) begin
            w_md_res = (mdop_q[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else if (!mdop_q[1]) begin
            w_md_res = negq_q ? -lo_d : lo_d;
        end else begin
            w_md_res = negr_q ? -hi_d : hi_d;
        end
    end
`endif

    always_comb begin
        w_src2  = (opcode_in == C_OP_REG) ? rs2_value_in : imm_value_in;
        w_shamt = w_src2[SHW-1:0];
        w_sub   = (opcode_in == C_OP_REG) && (funct3_in == 3'b000) && (funct7_in == 7'h20);
        w_sra   = (opcode_in == C_OP_REG) ? funct7_in[5] : imm_value_in[10];
        w_legal = 1'b1;
        w_alu   = '0;
`ifdef ALU_SEQ_MULDIV_EN
        w_is_md = 1'b0;
`endif
        case (funct3_in)
            3'b000:  w_alu = w_sub ? rs1_value_in - w_src2 : rs1_value_in + w_src2;
            3'b001:  w_alu = rs1_value_in << w_shamt;
            3'b010:  w_alu = {{(XLEN-1){1'b0}}, ($signed(rs1_value_in) < $signed(w_src2))};
            3'b011:  w_alu = {{(XLEN-1){1'b0}}, (rs1_value_in < w_src2)};
            3'b100:  w_alu = rs1_value_in ^ w_src2;
            3'b101:  w_alu = w_sra ? $unsigned($signed(rs1_value_in) >>> w_shamt)
                                   : rs1_value_in >> w_shamt;
            3'b110:  w_alu = rs1_value_in | w_src2;
            default: w_alu = rs1_value_in & w_src2;
        endcase
        case (opcode_in)
            C_OP_LOAD, C_OP_STORE: w_alu = rs1_value_in + imm_value_in;
            C_OP_IMM:              w_legal = 1'b1;
            C_OP_REG: begin
                if (funct7_in == 7'h20) begin
                    w_legal = (funct3_in == 3'b000) || (funct3_in == 3'b101);
`ifdef ALU_SEQ_MULDIV_EN
                end else if (funct7_in == 7'h01) begin
                    w_is_md = 1'b1;
                    w_alu   = w_fast_res;
`endif
                end else begin
                    w_legal = (funct7_in == 7'h00);
                end
            end
            default:               w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_alu = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
`ifdef ALU_SEQ_MULDIV_EN
            cnt_q     <= '0;
            mdop_q    <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
`ifdef ALU_SEQ_MULDIV_EN
                        if (w_is_md && !w_fast) begin
                            state_q <= S_ITER;
                            cnt_q   <= '0;
                            mdop_q  <= funct3_in;
                            negq_q  <= w_n1 ^ w_n2;
                            negr_q  <= w_n1;
                            a_q     <= funct3_in[2] ? w_abs2 : w_abs1;
                            lo_q    <= funct3_in[2] ? w_abs1 : w_abs2;
                            hi_q    <= '0;
                        end else begin
                            state_q   <= S_DONE;
                            valid_q   <= 1'b1;
                            result_q  <= w_alu;
                            illegal_q <= ~w_legal;
                        end
`else
                        state_q   <= S_DONE;
                        valid_q   <= 1'b1;
                        result_q  <= w_alu;
                        illegal_q <= ~w_legal;
`endif
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                S_ITER: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHW'(XLEN-1)) begin
                        state_q   <= S_DONE;
                        valid_q   <= 1'b1;
                        result_q  <= w_md_res;
                        illegal_q <= 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out   = (state_q == S_IDLE);
    assign valid_out   = valid_q;
    assign result_out  = result_q;
    assign illegal_out = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Scoreboard testbench for alu_seq (XLEN=32), both macro builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        valid_in;
    logic        ready_out;
    logic [6:0]  opcode_in;
    logic [2:0]  funct3_in;
    logic [6:0]  funct7_in;
    logic [31:0] rs1_value_in;
    logic [31:0] rs2_value_in;
    logic [31:0] imm_value_in;
    logic        valid_out;
    logic [31:0] result_out;
    logic        illegal_out;

    typedef struct packed {
        logic [31:0] res;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] obs_res;
    logic        obs_ill;
    int          obs_lat;
    bit          obs_to;

    always #5 clk_in = ~clk_in;

    alu_seq #(.XLEN(32)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .opcode_in    (opcode_in),
        .funct3_in    (funct3_in),
        .funct7_in    (funct7_in),
        .rs1_value_in (rs1_value_in),
        .rs2_value_in (rs2_value_in),
        .imm_value_in (imm_value_in),
        .valid_out    (valid_out),
        .result_out   (result_out),
        .illegal_out  (illegal_out)
    );

    // Reference model: returns {illegal, result}.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
        logic [31:0] s2;
        logic [31:0] r;
        logic [63:0] p;
        logic [4:0]  sh;
        int          sa;
        int          sbv;
        int          q;
        s2  = (op == 7'h33) ? b : imm;
        sh  = s2[4:0];
        sa  = a;
        sbv = b;
        r   = '0;
        if (op == 7'h03 || op == 7'h23) return {1'b0, a + imm};
        if (op != 7'h13 && op != 7'h33) return {1'b1, 32'h0};
        if (op == 7'h33 && f7 == 7'h01) begin
            if (!MD) return {1'b1, 32'h0};
            case (f3)
                3'd0: r = a * b;
                3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
                3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); r = p[63:32]; end
                3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
                3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd7: r = (b == 0) ? a : a % b;
                default: begin
                    if (b == 0) r = f3[1] ? a : 32'hFFFF_FFFF;
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = f3[1] ? 32'h0 : a;
                    else begin
                        if (f3[1]) q = sa % sbv;
                        else       q = sa / sbv;
                        r = q;
                    end
                end
            endcase
            return {1'b0, r};
        end
        if (op == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
            return {1'b1, 32'h0};
        case (f3)
            3'd0: r = (op == 7'h33 && f7 == 7'h20) ? a - s2 : a + s2;
            3'd1: r = a << sh;
            3'd2: if ($signed(a) < $signed(s2)) r = 32'd1;
            3'd3: if (a < s2) r = 32'd1;
            3'd4: r = a ^ s2;
            3'd5: begin
                if ((op == 7'h33) ? f7[5] : imm[10]) r = $signed(a) >>> sh;
                else                                 r = a >> sh;
            end
            3'd6: r = a | s2;
            default: r = a & s2;
        endcase
        return {1'b0, r};
    endfunction

    // Issues one request with a single-cycle valid pulse and captures the response.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        @(negedge clk_in);
        opcode_in = op; funct3_in = f3; funct7_in = f7;
        rs1_value_in = a; rs2_value_in = b; imm_value_in = imm;
        valid_in = 1'b1;
        @(posedge clk_in);
        #1 valid_in = 1'b0;
        obs_to = 1'b1; obs_lat = 0; obs_res = '0; obs_ill = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_in);
            if (valid_out) begin
                obs_to = 1'b0; obs_lat = i; obs_res = result_out; obs_ill = illegal_out;
                break;
            end
        end
    endtask

    function automatic exp_t mk(input logic [32:0] m, input int lat);
        exp_t e;
        e.ill = m[32];
        e.res = m[31:0];
        e.lat = 8'(lat);
        return e;
    endfunction

    task automatic test_reset();
        reset_in = 1'b1; valid_in = 1'b1;
        opcode_in = 7'h33; funct3_in = 3'd0; funct7_in = 7'h00;
        rs1_value_in = 32'd1; rs2_value_in = 32'd1; imm_value_in = 32'd0;
        repeat (2) @(negedge clk_in);
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (result_out !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result_out); end
        checks++; if (illegal_out !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal_out); end
        reset_in = 1'b0; valid_in = 1'b0;
        @(negedge clk_in);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_dominates: valid_out %b want 0", valid_out); end
    endtask

    task automatic test_alu();
        typedef struct packed { logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [31:0] a, b, imm; } st_t;
        st_t  tbl[14];
        exp_t e;
        tbl[0]  = '{7'h33, 3'd0, 7'h00, 32'd5, 32'hFFFF_FFFF, 32'd0};
        tbl[1]  = '{7'h33, 3'd0, 7'h20, 32'd3, 32'd5, 32'd0};
        tbl[2]  = '{7'h13, 3'd0, 7'h20, 32'd10, 32'd99, 32'd3};
        tbl[3]  = '{7'h33, 3'd4, 7'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0};
        tbl[4]  = '{7'h13, 3'd6, 7'h00, 32'h1200_0000, 32'd0, 32'hFFFF_F800};
        tbl[5]  = '{7'h33, 3'd7, 7'h00, 32'hDEAD_BEEF, 32'h00FF_FF00, 32'd0};
        tbl[6]  = '{7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0};
        tbl[7]  = '{7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0};
        tbl[8]  = '{7'h13, 3'd2, 7'h00, 32'd4, 32'd0, 32'hFFFF_FFFF};
        tbl[9]  = '{7'h03, 3'd5, 7'h7F, 32'h1000, 32'd7, 32'hFFFF_FFFC};
        tbl[10] = '{7'h23, 3'd2, 7'h20, 32'h2000, 32'd7, 32'h10};
        tbl[11] = '{7'h33, 3'd1, 7'h20, 32'd1, 32'd1, 32'd0};
        tbl[12] = '{7'h33, 3'd0, 7'h40, 32'd1, 32'd1, 32'd0};
        tbl[13] = '{7'h7F, 3'd0, 7'h00, 32'd9, 32'd9, 32'd9};
        for (int i = 0; i < 14; i++) begin
            sb.push_back(mk(model(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].a, tbl[i].b, tbl[i].imm), 1));
            send(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].a, tbl[i].b, tbl[i].imm);
            e = sb.pop_front();
            checks++;
            if (obs_to || obs_res !== e.res || obs_ill !== e.ill || obs_lat != int'(e.lat)) begin
                errors++;
                $display("FAIL alu[%0d]: res=%h ill=%b lat=%0d timeout=%0b, expected res=%h ill=%b lat=%0d",
                         i, obs_res, obs_ill, obs_lat, obs_to, e.res, e.ill, e.lat);
            end
            @(negedge clk_in);
            checks++;
            if (result_out !== e.res) begin
                errors++; $display("FAIL alu_hold[%0d]: result_out=%h expected %h", i, result_out, e.res);
            end
        end
    endtask

    task automatic test_shift();
        logic [31:0] ops[5][3];
        logic [6:0]  opc[5];
        logic [6:0]  f7[5];
        logic [2:0]  f3[5];
        logic [31:0] want[5];
        exp_t        e;
        opc[0] = 7'h13; f3[0] = 3'd5; f7[0] = 7'h00; ops[0] = '{32'h8000_0000, 32'd0, 32'h41F}; want[0] = 32'hFFFF_FFFF;
        opc[1] = 7'h13; f3[1] = 3'd5; f7[1] = 7'h00; ops[1] = '{32'h8000_0000, 32'd0, 32'h01F}; want[1] = 32'h0000_0001;
        opc[2] = 7'h13; f3[2] = 3'd1; f7[2] = 7'h00; ops[2] = '{32'd3, 32'd0, 32'h21};           want[2] = 32'd6;
        opc[3] = 7'h33; f3[3] = 3'd5; f7[3] = 7'h20; ops[3] = '{32'hF000_0000, 32'h24, 32'd0};   want[3] = 32'hFF00_0000;
        opc[4] = 7'h33; f3[4] = 3'd5; f7[4] = 7'h00; ops[4] = '{32'hF000_0000, 32'h24, 32'd0};   want[4] = 32'h0F00_0000;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk({1'b0, want[i]}, 1));
            send(opc[i], f3[i], f7[i], ops[i][0], ops[i][1], ops[i][2]);
            e = sb.pop_front();
            checks++;
            if (obs_to || obs_res !== e.res || obs_ill !== e.ill || obs_lat != int'(e.lat)) begin
                errors++;
                $display("FAIL shift[%0d]: res=%h ill=%b lat=%0d timeout=%0b, expected res=%h ill=%b lat=%0d",
                         i, obs_res, obs_ill, obs_lat, obs_to, e.res, e.ill, e.lat);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, imm, x;
        exp_t        e;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       op = 7'h33;
                1:       op = 7'h13;
                2:       op = 7'h03;
                default: op = 7'h23;
            endcase
            f3 = 3'($urandom);
            f7 = 7'h00;
            if (op == 7'h33 && (f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
            a = $urandom; b = $urandom; x = $urandom;
            imm = {{20{x[11]}}, x[11:0]};
            sb.push_back(mk(model(op, f3, f7, a, b, imm), 1));
            send(op, f3, f7, a, b, imm);
            e = sb.pop_front();
            checks++;
            if (obs_to || obs_res !== e.res || obs_ill !== e.ill || obs_lat != int'(e.lat)) begin
                errors++;
                $display("FAIL random[%0d] op=%h f3=%0d f7=%h: res=%h ill=%b lat=%0d timeout=%0b, expected res=%h ill=%b lat=%0d",
                         i, op, f3, f7, obs_res, obs_ill, obs_lat, obs_to, e.res, e.ill, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_in);
        opcode_in = 7'h7F; funct3_in = 3'd0; funct7_in = 7'h00;
        rs1_value_in = 32'd123; rs2_value_in = 32'd4; imm_value_in = 32'd5;
        valid_in = 1'b1;
        @(posedge clk_in);
        #1 opcode_in = 7'h33; rs1_value_in = 32'd1; rs2_value_in = 32'd1;
        @(negedge clk_in);
        checks++;
        if (valid_out !== 1'b1 || result_out !== 32'h0 || illegal_out !== 1'b1 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_illegal: valid=%b res=%h ill=%b ready=%b, expected 1 0 1 0",
                     valid_out, result_out, illegal_out, ready_out);
        end
        @(negedge clk_in);
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL b2b_idle: valid=%b ready=%b, expected 0 1", valid_out, ready_out);
        end
        @(negedge clk_in);
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b1 || result_out !== 32'd2 || illegal_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reaccept: valid=%b res=%h ill=%b, expected 1 00000002 0",
                     valid_out, result_out, illegal_out);
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset_dominance();
        exp_t e;
        sb.push_back(mk({1'b0, 32'd8}, 1));
        send(7'h33, 3'd0, 7'h00, 32'd7, 32'd1, 32'd0);
        e = sb.pop_front();
        checks++;
        if (obs_to || obs_res !== e.res || obs_lat != int'(e.lat)) begin
            errors++; $display("FAIL pre_reset: res=%h lat=%0d, expected %h lat %0d", obs_res, obs_lat, e.res, e.lat);
        end
        @(negedge clk_in);
        reset_in = 1'b1; valid_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (result_out !== 32'h0 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL reset_clear: res=%h valid=%b ready=%b, expected 0 0 1", result_out, valid_out, ready_out);
        end
        reset_in = 1'b0; valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_no_accept: valid_out=%b expected 0", valid_out);
        end
    endtask

`ifdef ALU_SEQ_MULDIV_EN
    task automatic test_muldiv();
        logic [2:0]  f3;
        logic [31:0] a, b;
        exp_t        e;
        int          lat;
        for (int i = 0; i < 26; i++) begin
            case (i)
                0: begin f3 = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2; end
                1: begin f3 = 3'd6; a = 32'hFFFF_FFF9; b = 32'd2; end
                2: begin f3 = 3'd5; a = 32'd1234;      b = 32'd0; end
                3: begin f3 = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                4: begin f3 = 3'd4; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                5: begin f3 = 3'd6; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                6: begin f3 = 3'd6; a = 32'd7;         b = 32'hFFFF_FFFD; end
                7: begin f3 = 3'd2; a = 32'hFFFF_FFFE; b = 32'hFFFF_FFFF; end
                8: begin f3 = 3'd7; a = 32'd99;        b = 32'd0; end
                9: begin f3 = 3'd1; a = 32'h8000_0000; b = 32'h8000_0000; end
                default: begin
                    f3 = 3'($urandom); a = $urandom;
                    b  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(1, 300)));
                end
            endcase
            lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
            sb.push_back(mk(model(7'h33, f3, 7'h01, a, b, 32'd0), lat));
            send(7'h33, f3, 7'h01, a, b, 32'd0);
            e = sb.pop_front();
            checks++;
            if (obs_to || obs_res !== e.res || obs_ill !== e.ill || obs_lat != int'(e.lat)) begin
                errors++;
                $display("FAIL muldiv[%0d] f3=%0d a=%h b=%h: res=%h ill=%b lat=%0d timeout=%0b, expected res=%h ill=%b lat=%0d",
                         i, f3, a, b, obs_res, obs_ill, obs_lat, obs_to, e.res, e.ill, e.lat);
            end
        end
    endtask

    task automatic test_iter_abort();
        bit seen;
        bit busy_ok;
        @(negedge clk_in);
        opcode_in = 7'h33; funct3_in = 3'd0; funct7_in = 7'h01;
        rs1_value_in = 32'd6; rs2_value_in = 32'd7; valid_in = 1'b1;
        @(posedge clk_in);
        #1 funct7_in = 7'h00;
        busy_ok = 1'b1; seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_in);
            if (ready_out !== 1'b0) busy_ok = 1'b0;
            if (valid_out) seen = 1'b1;
        end
        checks++;
        if (!busy_ok) begin errors++; $display("FAIL iter_busy: ready_out rose during ITER, expected 0"); end
        reset_in = 1'b1; valid_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++; $display("FAIL iter_abort: ready=%b valid=%b, expected 1 0", ready_out, valid_out);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (valid_out) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL iter_no_pulse: valid_out seen=1 expected 0"); end
    endtask
`else
    task automatic test_muldiv_disabled();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk({1'b1, 32'h0}, 1));
            send(7'h33, 3'(i * 3), 7'h01, 32'd6, 32'd7, 32'd0);
            e = sb.pop_front();
            checks++;
            if (obs_to || obs_res !== e.res || obs_ill !== e.ill || obs_lat != int'(e.lat)) begin
                errors++;
                $display("FAIL md_disabled[%0d]: res=%h ill=%b lat=%0d timeout=%0b, expected res=%h ill=%b lat=%0d",
                         i, obs_res, obs_ill, obs_lat, obs_to, e.res, e.ill, e.lat);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in = 1'b1; valid_in = 1'b0;
        opcode_in = '0; funct3_in = '0; funct7_in = '0;
        rs1_value_in = '0; rs2_value_in = '0; imm_value_in = '0;
        test_reset();
        test_alu();
        test_shift();
        test_random();
        test_back_to_back();
        test_reset_dominance();
`ifdef ALU_SEQ_MULDIV_EN
        test_muldiv();
        test_iter_abort();
`else
        test_muldiv_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
